// File: rtl/axi_err_slave_param.sv
// AXI default slave: completes every AW/W and AR burst with a fixed error response,
// with saturating error counters and last-error address capture for debug readout.
module axi_err_slave_param #(
  parameter int          DATA_W = 128,
  parameter int          ID_W   = 8,
  parameter int          ADDR_W = 40,
  parameter int          LEN_W  = 8,
  parameter logic [1:0]  RESP   = 2'b10,
  parameter int          RD_LAT = 1,
  parameter int          CNT_W  = 16
) (
  input  logic                pll_core_cpuclk,
  input  logic                pad_cpu_rst,
  input  logic                awvalid_s1,
  output logic                awready_s1,
  input  logic [ID_W-1:0]     awid_s1,
  input  logic [ADDR_W-1:0]   awaddr_s1,
  input  logic [LEN_W-1:0]    awlen_s1,
  input  logic                wvalid_s1,
  output logic                wready_s1,
  input  logic                wlast_s1,
  input  logic [DATA_W-1:0]   wdata_s1,
  input  logic [DATA_W/8-1:0] wstrb_s1,
  output logic                bvalid_s1,
  input  logic                bready_s1,
  output logic [ID_W-1:0]     bid_s1,
  output logic [1:0]          bresp_s1,
  input  logic                arvalid_s1,
  output logic                arready_s1,
  input  logic [ID_W-1:0]     arid_s1,
  input  logic [ADDR_W-1:0]   araddr_s1,
  input  logic [LEN_W-1:0]    arlen_s1,
  output logic                rvalid_s1,
  input  logic                rready_s1,
  output logic [ID_W-1:0]     rid_s1,
  output logic [DATA_W-1:0]   rdata_s1,
  output logic [1:0]          rresp_s1,
  output logic                rlast_s1,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    err_rd_cnt,
  output logic [CNT_W-1:0]    err_wr_cnt,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                wlast_err
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_st_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_st_t;

  localparam logic [3:0]       LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  w_st_t             w_st_q, w_st_d;
  r_st_t             r_st_q, r_st_d;
  logic [ID_W-1:0]   awid_q, awid_d, arid_q, arid_d;
  logic [LEN_W-1:0]  awlen_q, awlen_d, arlen_q, arlen_d;
  logic [LEN_W-1:0]  wbeat_q, wbeat_d, rbeat_q, rbeat_d;
  logic [3:0]        lat_q, lat_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              wlast_err_q, wlast_err_d;
  logic              aw_hs_s, ar_hs_s, wlast_mis_s;

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      w_st_q      <= W_IDLE;
      r_st_q      <= R_IDLE;
      awid_q      <= {ID_W{1'b0}};
      arid_q      <= {ID_W{1'b0}};
      awlen_q     <= {LEN_W{1'b0}};
      arlen_q     <= {LEN_W{1'b0}};
      wbeat_q     <= {LEN_W{1'b0}};
      rbeat_q     <= {LEN_W{1'b0}};
      lat_q       <= 4'd0;
      rd_cnt_q    <= {CNT_W{1'b0}};
      wr_cnt_q    <= {CNT_W{1'b0}};
      err_addr_q  <= {ADDR_W{1'b0}};
      wlast_err_q <= 1'b0;
    end else begin
      w_st_q      <= w_st_d;
      r_st_q      <= r_st_d;
      awid_q      <= awid_d;
      arid_q      <= arid_d;
      awlen_q     <= awlen_d;
      arlen_q     <= arlen_d;
      wbeat_q     <= wbeat_d;
      rbeat_q     <= rbeat_d;
      lat_q       <= lat_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      err_addr_q  <= err_addr_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  // Write burst terminates on beat count alone; wlast is only checked for consistency.
  always_comb begin
    w_st_d  = w_st_q;
    awid_d  = awid_q;
    awlen_d = awlen_q;
    wbeat_d = wbeat_q;
    case (w_st_q)
      W_IDLE: begin
        if (awvalid_s1) begin
          awid_d  = awid_s1;
          awlen_d = awlen_s1;
          wbeat_d = {LEN_W{1'b0}};
          w_st_d  = W_DATA;
        end else begin
          w_st_d  = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid_s1) begin
          wbeat_d = wbeat_q + {{(LEN_W-1){1'b0}}, 1'b1};
          if (wbeat_q == awlen_q) begin
            w_st_d = W_RESP;
          end else begin
            w_st_d = W_DATA;
          end
        end else begin
          w_st_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bready_s1) begin
          w_st_d = W_IDLE;
        end else begin
          w_st_d = W_RESP;
        end
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_st_d  = r_st_q;
    arid_d  = arid_q;
    arlen_d = arlen_q;
    rbeat_d = rbeat_q;
    lat_d   = lat_q;
    case (r_st_q)
      R_IDLE: begin
        if (arvalid_s1) begin
          arid_d  = arid_s1;
          arlen_d = arlen_s1;
          rbeat_d = {LEN_W{1'b0}};
          lat_d   = 4'd0;
          r_st_d  = (RD_LAT == 0) ? R_DATA : R_WAIT;
        end else begin
          r_st_d  = R_IDLE;
        end
      end
      R_WAIT: begin
        if (lat_q == LAT_LAST) begin
          r_st_d = R_DATA;
        end else begin
          lat_d  = lat_q + 4'd1;
        end
      end
      R_DATA: begin
        if (rready_s1) begin
          if (rbeat_q == arlen_q) begin
            r_st_d  = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end else begin
          r_st_d = R_DATA;
        end
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  // Debug state: a clear coinciding with a new event keeps the new event.
  always_comb begin
    aw_hs_s     = (w_st_q == W_IDLE) && awvalid_s1;
    ar_hs_s     = (r_st_q == R_IDLE) && arvalid_s1;
    wlast_mis_s = (w_st_q == W_DATA) && wvalid_s1 && (wlast_s1 != (wbeat_q == awlen_q));
    if (err_clr) begin
      wr_cnt_d = aw_hs_s ? CNT_ONE : {CNT_W{1'b0}};
      rd_cnt_d = ar_hs_s ? CNT_ONE : {CNT_W{1'b0}};
    end else begin
      wr_cnt_d = (aw_hs_s && (wr_cnt_q != CNT_MAX)) ? wr_cnt_q + CNT_ONE : wr_cnt_q;
      rd_cnt_d = (ar_hs_s && (rd_cnt_q != CNT_MAX)) ? rd_cnt_q + CNT_ONE : rd_cnt_q;
    end
    if (ar_hs_s) begin
      err_addr_d = araddr_s1;
    end else if (aw_hs_s) begin
      err_addr_d = awaddr_s1;
    end else if (err_clr) begin
      err_addr_d = {ADDR_W{1'b0}};
    end else begin
      err_addr_d = err_addr_q;
    end
    if (wlast_mis_s) begin
      wlast_err_d = 1'b1;
    end else if (err_clr) begin
      wlast_err_d = 1'b0;
    end else begin
      wlast_err_d = wlast_err_q;
    end
  end

  always_comb begin
    awready_s1 = (w_st_q == W_IDLE);
    wready_s1  = (w_st_q == W_DATA);
    bvalid_s1  = (w_st_q == W_RESP);
    bid_s1     = awid_q;
    bresp_s1   = RESP;
    arready_s1 = (r_st_q == R_IDLE);
    rvalid_s1  = (r_st_q == R_DATA);
    rid_s1     = arid_q;
    rdata_s1   = {DATA_W{1'b0}};
    rresp_s1   = RESP;
    rlast_s1   = (r_st_q == R_DATA) && (rbeat_q == arlen_q);
    err_rd_cnt = rd_cnt_q;
    err_wr_cnt = wr_cnt_q;
    err_addr   = err_addr_q;
    wlast_err  = wlast_err_q;
  end

endmodule

// File: tb/tb_axi_err_slave_param.sv
// Scoreboard bench for axi_err_slave_param: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them and checks stability while stalled.
module tb_axi_err_slave_param;
  localparam int DATA_W = 128, ID_W = 8, ADDR_W = 40, LEN_W = 8, CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
  logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0, err_addr;
  logic [LEN_W-1:0] awlen = '0, arlen = '0;
  logic [DATA_W-1:0] wdata = '0, rdata;
  logic [DATA_W/8-1:0] wstrb = '1;
  logic bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1, rlast;
  logic [1:0] bresp, rresp;
  logic err_clr = 1'b0, wlast_err;
  logic [CNT_W-1:0] err_rd_cnt, err_wr_cnt;

  axi_err_slave_param #(.DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .RESP(2'b10), .RD_LAT(1), .CNT_W(CNT_W)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .awvalid_s1(awvalid), .awready_s1(awready), .awid_s1(awid), .awaddr_s1(awaddr), .awlen_s1(awlen),
    .wvalid_s1(wvalid), .wready_s1(wready), .wlast_s1(wlast), .wdata_s1(wdata), .wstrb_s1(wstrb),
    .bvalid_s1(bvalid), .bready_s1(bready), .bid_s1(bid), .bresp_s1(bresp),
    .arvalid_s1(arvalid), .arready_s1(arready), .arid_s1(arid), .araddr_s1(araddr), .arlen_s1(arlen),
    .rvalid_s1(rvalid), .rready_s1(rready), .rid_s1(rid), .rdata_s1(rdata), .rresp_s1(rresp),
    .rlast_s1(rlast), .err_clr(err_clr), .err_rd_cnt(err_rd_cnt), .err_wr_cnt(err_wr_cnt),
    .err_addr(err_addr), .wlast_err(wlast_err));

  typedef struct packed { logic [ID_W-1:0] id; logic last; } rexp_t;
  rexp_t r_q[$];
  logic [ID_W-1:0] b_q[$];
  int checks = 0, errors = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Ready driver: always-accept or random back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) begin
        rready = 1'($urandom_range(0, 1));
        bready = 1'($urandom_range(0, 1));
      end else begin
        rready = 1'b1;
        bready = 1'b1;
      end
    end
  end

  // Monitor: pop expected response on each handshake, check held values while stalled.
  bit r_hold = 1'b0, b_hold = 1'b0;
  logic [ID_W-1:0] r_hid, b_hid;
  logic r_hlast;
  always @(negedge clk) begin
    rexp_t e;
    if (rst) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("r_stall_valid", 64'(rvalid), 64'd1);
        chk("r_stall_id", 64'(rid), 64'(r_hid));
        chk("r_stall_last", 64'(rlast), 64'(r_hlast));
      end
      if (b_hold) begin
        chk("b_stall_valid", 64'(bvalid), 64'd1);
        chk("b_stall_id", 64'(bid), 64'(b_hid));
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=beat id %0h expected=none", rid);
        end else begin
          e = r_q.pop_front();
          chk("r_id", 64'(rid), 64'(e.id));
          chk("r_last", 64'(rlast), 64'(e.last));
          chk("r_resp", 64'(rresp), 64'd2);
          chk("r_data_nonzero", 64'(|rdata), 64'd0);
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=id %0h expected=none", bid);
        end else begin
          chk("b_id", 64'(bid), 64'(b_q.pop_front()));
          chk("b_resp", 64'(bresp), 64'd2);
        end
      end
      r_hold = rvalid && !rready; r_hid = rid; r_hlast = rlast;
      b_hold = bvalid && !bready; b_hid = bid;
    end
  end

  // Issue AW and/or AR in the same cycle (FSMs must be idle); optional err_clr alongside.
  task automatic issue(input bit do_aw, input logic [ID_W-1:0] wid, input logic [ADDR_W-1:0] waddr,
                       input logic [LEN_W-1:0] wlen, input bit do_ar, input logic [ID_W-1:0] rd_id,
                       input logic [ADDR_W-1:0] raddr, input logic [LEN_W-1:0] rlen, input bit clr);
    int n = 0;
    @(posedge clk); #1;
    awvalid = do_aw; awid = wid; awaddr = waddr; awlen = wlen;
    arvalid = do_ar; arid = rd_id; araddr = raddr; arlen = rlen;
    err_clr = clr;
    @(negedge clk);
    while (((do_aw && !awready) || (do_ar && !arready)) && n < 200) begin @(negedge clk); n++; end
    chk("handshake_timeout", 64'(n < 200), 64'd1);
    if (do_aw) b_q.push_back(wid);
    if (do_ar) for (int i = 0; i <= int'(rlen); i++) r_q.push_back('{id: rd_id, last: (i == int'(rlen))});
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0; err_clr = 1'b0;
    if (do_ar) begin
      chk("r_latency_idle", 64'(rvalid), 64'd0);
      @(posedge clk); #1;
      chk("r_first_beat", 64'(rvalid), 64'd1);
    end
  endtask

  task automatic send_w(input int len, input int last_at);
    int n;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wlast = (i == last_at); wdata = {4{$urandom}};
      n = 0;
      @(negedge clk);
      while (!wready && n < 200) begin @(negedge clk); n++; end
      chk("w_beat_timeout", 64'(n < 200), 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || rvalid || bvalid) && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    chk("idle_timeout", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_ids", 64'({bid, rid}), 64'd0);
    chk("rst_dbg", 64'({err_rd_cnt, err_wr_cnt, wlast_err}), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    rst = 1'b0;

    // Basic write: id 5, 4 beats, wlast correct.
    issue(1'b1, 8'd5, 40'h1000, 8'd3, 1'b0, '0, '0, '0, 1'b0);
    send_w(3, 3);
    wait_idle();
    chk("wr_cnt_1", 64'(err_wr_cnt), 64'd1);
    chk("wlast_err_0", 64'(wlast_err), 64'd0);
    chk("err_addr_aw", 64'(err_addr), 64'h1000);

    // Basic read: id 9, 8 beats, latency checked inside issue.
    issue(1'b0, '0, '0, '0, 1'b1, 8'd9, 40'h4000, 8'd7, 1'b0);
    wait_idle();
    chk("err_addr_ar", 64'(err_addr), 64'h4000);
    chk("rd_cnt_1", 64'(err_rd_cnt), 64'd1);

    // Clear alone, then concurrent AR/AW.
    issue(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    chk("clr_dbg", 64'({err_rd_cnt, err_wr_cnt, wlast_err}), 64'd0);
    chk("clr_err_addr", 64'(err_addr), 64'd0);
    issue(1'b1, 8'd1, 40'h200, 8'd1, 1'b1, 8'd2, 40'h100, 8'd2, 1'b0);
    send_w(1, 1);
    wait_idle();
    chk("conc_err_addr", 64'(err_addr), 64'h100);
    chk("conc_rd_cnt", 64'(err_rd_cnt), 64'd1);
    chk("conc_wr_cnt", 64'(err_wr_cnt), 64'd1);

    // Random back-pressure on R and B.
    rand_ready = 1'b1;
    issue(1'b1, 8'h33, 40'h300, 8'd2, 1'b1, 8'h44, 40'h400, 8'd5, 1'b0);
    send_w(2, 2);
    wait_idle();
    issue(1'b1, 8'h55, 40'h500, 8'd0, 1'b1, 8'h66, 40'h600, 8'd3, 1'b0);
    send_w(0, 0);
    wait_idle();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Early wlast: burst still runs 4 beats.
    issue(1'b1, 8'd7, 40'h700, 8'd3, 1'b0, '0, '0, '0, 1'b0);
    send_w(3, 1);
    wait_idle();
    chk("wlast_err_1", 64'(wlast_err), 64'd1);

    // Maximum burst length.
    issue(1'b0, '0, '0, '0, 1'b1, 8'hAA, 40'h8000, 8'd255, 1'b0);
    wait_idle();

    // Saturation, then clear coinciding with an AR.
    issue(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++) issue(1'b0, '0, '0, '0, 1'b1, 8'(k), 40'(k * 16), 8'd0, 1'b0);
    wait_idle();
    chk("rd_cnt_sat", 64'(err_rd_cnt), 64'd3);
    issue(1'b0, '0, '0, '0, 1'b1, 8'h77, 40'h7700, 8'd0, 1'b1);
    chk("rd_cnt_clr_hs", 64'(err_rd_cnt), 64'd1);
    chk("err_addr_clr_hs", 64'(err_addr), 64'h7700);
    wait_idle();

    // Reset in the middle of R_DATA abandons the burst.
    issue(1'b0, '0, '0, '0, 1'b1, 8'h12, 40'h9000, 8'd7, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_rvalid_edge", 64'(rvalid), 64'd0);
    chk("rst_mid_arready", 64'(arready), 64'd1);
    chk("rst_mid_rd_cnt", 64'(err_rd_cnt), 64'd0);
    r_q.delete();
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_rvalid", 64'(rvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
